// File: rtl/mac_sequencer.sv
// Control sequencer for a single multiply-accumulate dot-product pass.
// Issues paired coefficient/sample reads, then strobes the T, P and ACC pipeline stages.
module mac_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_taps,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic [ADDR_W-1:0] data_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] data_addr,
  output logic              t_load,
  output logic              p_load,
  output logic              acc_clr,
  output logic              acc_add
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic              t_load_q, t_load_d;
  logic              p_load_q, p_load_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_add_q, acc_add_d;

  // The state register leads the outputs by one cycle: every output is computed
  // here from the current state and appears registered in the following cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_rd_d    = 1'b0;
    acc_clr_d   = 1'b0;
    coef_addr_d = coef_addr_q;
    data_addr_d = data_addr_q;
    t_load_d    = mem_rd_q;
    p_load_d    = t_load_q;
    acc_add_d   = p_load_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d         = num_taps;
          idx_d       = '0;
          busy_d      = 1'b1;
          acc_clr_d   = 1'b1;
          coef_addr_d = coef_base;
          data_addr_d = data_base;
          if (num_taps != '0) begin
            mem_rd_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d  = DONE;
          end
        end
      end

      ISSUE: begin
        busy_d = 1'b1;
        // idx_q is the tap whose read is on the bus this cycle; n_q is nonzero here.
        if (idx_q == n_q - CNT_ONE) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d       = idx_q + CNT_ONE;
          mem_rd_d    = 1'b1;
          coef_addr_d = coef_addr_q + ADDR_ONE;
          data_addr_d = data_addr_q + ADDR_ONE;
        end
      end

      DRAIN: begin
        busy_d = 1'b1;
        if (idx_q[0]) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNT_ONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      coef_addr_q <= '0;
      data_addr_q <= '0;
      t_load_q    <= 1'b0;
      p_load_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_add_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      coef_addr_q <= coef_addr_d;
      data_addr_q <= data_addr_d;
      t_load_q    <= t_load_d;
      p_load_q    <= p_load_d;
      acc_clr_q   <= acc_clr_d;
      acc_add_q   <= acc_add_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign coef_addr = coef_addr_q;
  assign data_addr = data_addr_q;
  assign t_load    = t_load_q;
  assign p_load    = p_load_q;
  assign acc_clr   = acc_clr_q;
  assign acc_add   = acc_add_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: stimulus queues expected strobe cycles,
// addresses and results; a negedge monitor pops and compares them.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_taps;
  logic [7:0] coef_base;
  logic [7:0] data_base;
  logic       busy, done, mem_rd, t_load, p_load, acc_clr, acc_add;
  logic [7:0] coef_addr, data_addr;

  mac_sequencer #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_taps  (num_taps),
    .coef_base (coef_base),
    .data_base (data_base),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .coef_addr (coef_addr),
    .data_addr (data_addr),
    .t_load    (t_load),
    .p_load    (p_load),
    .acc_clr   (acc_clr),
    .acc_add   (acc_add)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expectation queues
  typedef struct { int cyc; logic [7:0] ca; logic [7:0] da; } rd_exp_t;
  typedef struct { int cyc; bit chk; int acc; } done_exp_t;
  typedef struct { int lo; int hi; } busy_win_t;

  localparam int EV_TL  = 0;
  localparam int EV_PL  = 1;
  localparam int EV_AA  = 2;
  localparam int EV_CLR = 3;
  string ev_name [4] = '{"t_load", "p_load", "acc_add", "acc_clr"};

  rd_exp_t   rd_q[$];
  int        ev_q[4][$];
  done_exp_t dn_q[$];
  busy_win_t bz_q[$];

  function automatic bit all_empty();
    return rd_q.size() == 0 && ev_q[0].size() == 0 && ev_q[1].size() == 0 &&
           ev_q[2].size() == 0 && ev_q[3].size() == 0 && dn_q.size() == 0 &&
           bz_q.size() == 0;
  endfunction

  task automatic flush();
    rd_q.delete();
    for (int k = 0; k < 4; k++) ev_q[k].delete();
    dn_q.delete();
    bz_q.delete();
  endtask

  // Expected behaviour of one pass accepted at the edge that starts cycle c0
  task automatic push_pass(input int n, input logic [7:0] cb, input logic [7:0] db,
                           input int c0, input bit chk, input int acc);
    logic [7:0] off;
    for (int i = 0; i < n; i++) begin
      off = 8'(i);
      rd_q.push_back('{c0 + i, cb + off, db + off});
      ev_q[EV_TL].push_back(c0 + i + 1);
      ev_q[EV_PL].push_back(c0 + i + 2);
      ev_q[EV_AA].push_back(c0 + i + 3);
    end
    ev_q[EV_CLR].push_back(c0);
    dn_q.push_back('{(n == 0) ? c0 + 1 : c0 + n + 3, chk, acc});
    bz_q.push_back('{c0, (n == 0) ? c0 : c0 + n + 2});
  endtask

  // Memory with 1-cycle read latency plus T/P/ACC datapath model
  logic signed [7:0]  coef_mem [256];
  logic signed [7:0]  data_mem [256];
  logic signed [7:0]  rd_c, rd_d, t_r, c_r;
  logic signed [15:0] p_r;
  logic signed [31:0] acc_r;

  always @(posedge clk) begin
    if (mem_rd) begin
      rd_c <= coef_mem[coef_addr];
      rd_d <= data_mem[data_addr];
    end
    if (t_load) begin
      t_r <= rd_d;
      c_r <= rd_c;
    end
    if (p_load) p_r <= t_r * c_r;
    if (acc_clr) acc_r <= '0;
    else if (acc_add) acc_r <= acc_r + 32'(p_r);
  end

  task automatic chk_evt(input int k, input logic seen);
    if (ev_q[k].size() > 0 && ev_q[k][0] < cyc) begin
      check($sformatf("%s_missing_at_%0d", ev_name[k], ev_q[k][0]), 0, 1);
      void'(ev_q[k].pop_front());
    end
    if (seen) begin
      if (ev_q[k].size() == 0) check({ev_name[k], "_unexpected"}, 1, 0);
      else check({ev_name[k], "_cycle"}, cyc, ev_q[k].pop_front());
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    rd_exp_t   re;
    done_exp_t de;
    bit        exp_busy;
    if (reset) begin
      if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        check($sformatf("mem_rd_missing_at_%0d", rd_q[0].cyc), 0, 1);
        void'(rd_q.pop_front());
      end
      if (mem_rd) begin
        if (rd_q.size() == 0) check("mem_rd_unexpected", 1, 0);
        else begin
          re = rd_q.pop_front();
          check("mem_rd_cycle", cyc, re.cyc);
          check("coef_addr", coef_addr, re.ca);
          check("data_addr", data_addr, re.da);
        end
      end
      chk_evt(EV_TL, t_load);
      chk_evt(EV_PL, p_load);
      chk_evt(EV_AA, acc_add);
      chk_evt(EV_CLR, acc_clr);
      if (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
        check($sformatf("done_missing_at_%0d", dn_q[0].cyc), 0, 1);
        void'(dn_q.pop_front());
      end
      if (done) begin
        if (dn_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          de = dn_q.pop_front();
          check("done_cycle", cyc, de.cyc);
          if (de.chk) check("acc_at_done", acc_r, de.acc);
        end
      end
      while (bz_q.size() > 0 && bz_q[0].hi < cyc) void'(bz_q.pop_front());
      exp_busy = (bz_q.size() > 0) && (bz_q[0].lo <= cyc);
      check("busy", busy, exp_busy);
    end
  end

  // Start one pass at the next edge; scramble the inputs right after accept
  task automatic issue(input int n, input logic [7:0] cb, input logic [7:0] db,
                       input bit chk, input int acc);
    @(negedge clk);
    num_taps  = 8'(n);
    coef_base = cb;
    data_base = db;
    start     = 1'b1;
    push_pass(n, cb, db, cyc + 1, chk, acc);
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_taps  = 8'($urandom);
    coef_base = 8'($urandom);
    data_base = 8'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && !all_empty(); i++) @(negedge clk);
    if (!all_empty()) begin
      check("drain_timeout", 0, 1);
      flush();
    end
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_coef_addr"}, coef_addr, 0);
    check({tag, "_data_addr"}, data_addr, 0);
    check({tag, "_t_load"}, t_load, 0);
    check({tag, "_p_load"}, p_load, 0);
    check({tag, "_acc_clr"}, acc_clr, 0);
    check({tag, "_acc_add"}, acc_add, 0);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    num_taps  = '0;
    coef_base = '0;
    data_base = '0;
    for (int a = 0; a < 256; a++) begin
      coef_mem[a] = '0;
      data_mem[a] = '0;
    end
    coef_mem[8'h30] = 8'sd1;  data_mem[8'h50] = 8'sd1;
    coef_mem[8'h31] = 8'sd3;  data_mem[8'h51] = 8'sd2;
    coef_mem[8'h32] = 8'sd5;  data_mem[8'h52] = -8'sd4;

    repeat (2) @(negedge clk);
    check_outputs_zero("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pass: 4 taps from 0x10 / 0x20
    issue(4, 8'h10, 8'h20, 1'b0, 0);
    wait_drain();

    // Zero taps
    issue(0, 8'h44, 8'h55, 1'b0, 0);
    wait_drain();

    // Address wrap
    issue(3, 8'hFE, 8'hFF, 1'b0, 0);
    wait_drain();

    // Datapath: (1,1),(2,3),(-4,5) -> 1 + 6 - 20 = -13
    issue(3, 8'h30, 8'h50, 1'b1, -13);
    wait_drain();

    // Start held high; inputs change after accept: one 2-tap pass, then a 9-tap one
    @(negedge clk);
    num_taps  = 8'd2;
    coef_base = 8'h60;
    data_base = 8'h70;
    start     = 1'b1;
    push_pass(2, 8'h60, 8'h70, cyc + 1, 1'b0, 0);
    push_pass(9, 8'h80, 8'h90, cyc + 7, 1'b0, 0);
    @(posedge clk);
    #1;
    num_taps  = 8'd9;
    coef_base = 8'h80;
    data_base = 8'h90;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();

    // Maximum tap count
    issue(255, 8'h01, 8'h02, 1'b0, 0);
    wait_drain();

    // Reset in the middle of ISSUE: outputs clear before the next edge, no done
    issue(4, 8'h10, 8'h20, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    flush();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // First start after reset is accepted normally
    issue(2, 8'hA0, 8'hB0, 1'b0, 0);
    wait_drain();

    check("queues_empty_at_end", all_empty(), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
